// File: rtl/keccak_job_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : keccak_job_scheduler
// Description : Shares one keccak_top core between NREQ 64-bit message
//               streams. Grants whole messages round-robin, streams the
//               granted message into the core, forwards the digest words
//               tagged with the requester id, then pulses the core reset.
// Revision    : 1.0 - initial release
// ============================================================================
module keccak_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int HS      = 512,
  parameter int TIMEOUT = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*64-1:0] req_data,
  input  logic [NREQ-1:0]    req_last,
  output logic [NREQ-1:0]    req_ready,
  output logic               core_rst,
  output logic               core_src_ready,
  input  logic               core_src_read,
  output logic [63:0]        core_din,
  output logic               core_dst_ready,
  input  logic               core_dst_write,
  input  logic [63:0]        core_dout,
  output logic               res_valid,
  output logic [63:0]        res_data,
  output logic [2:0]         res_id,
  output logic               res_last,
  input  logic               res_ready,
  output logic               busy,
  output logic               err
);

  localparam int c_OUT_WORDS = HS / 64;
  localparam int c_PW        = $clog2(NREQ);
  localparam int c_WW        = $clog2(c_OUT_WORDS);
  localparam int c_TW        = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FEED    = 2'd1,
    S_COLLECT = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [c_PW-1:0]   r_ptr, w_ptr_nxt;
  logic [c_PW-1:0]   r_grant, w_grant_nxt;
  logic [c_WW-1:0]   r_wcnt, w_wcnt_nxt;
  logic [c_TW-1:0]   r_tcnt, w_tcnt_nxt;
  logic              r_fcnt, w_fcnt_nxt;

  logic [63:0]       w_words [NREQ];
  logic [c_PW-1:0]   w_sel;
  logic [c_PW-1:0]   w_idx;
  logic              w_any;
  logic              w_feed_acc;
  logic              w_res_acc;

  // Per-requester views of the packed data bus
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_words[g] = req_data[64*g +: 64];
  end

  // Round-robin pick: first valid requester after the last one served
  always_comb begin
    w_sel = r_ptr;
    w_idx = r_ptr;
    w_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = c_PW'((int'(r_ptr) + k) % NREQ);
      if (!w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  // Next-state and output decode
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_grant_nxt    = r_grant;
    w_wcnt_nxt     = r_wcnt;
    w_tcnt_nxt     = r_tcnt;
    w_fcnt_nxt     = r_fcnt;
    w_feed_acc     = 1'b0;
    w_res_acc      = 1'b0;
    req_ready      = '0;
    core_rst       = reset;
    core_src_ready = 1'b1;
    core_din       = w_words[r_grant];
    core_dst_ready = 1'b1;
    res_valid      = 1'b0;
    res_data       = core_dout;
    res_id         = 3'(r_grant);
    res_last       = 1'b0;
    busy           = (r_state != S_IDLE);
    err            = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_grant_nxt = w_sel;
          w_state_nxt = S_FEED;
        end
      end

      S_FEED: begin
        // Core src_ready is active-low: 0 means din carries a word
        core_src_ready     = ~req_valid[r_grant];
        w_feed_acc         = core_src_read & req_valid[r_grant];
        req_ready[r_grant] = w_feed_acc;
        if (w_feed_acc && req_last[r_grant]) begin
          w_state_nxt = S_COLLECT;
          w_wcnt_nxt  = '0;
          w_tcnt_nxt  = '0;
        end
      end

      S_COLLECT: begin
        // Core holds dst_write while dst_ready stays high, so backpressure is lossless
        core_dst_ready = ~res_ready;
        res_valid      = core_dst_write;
        res_last       = core_dst_write & (r_wcnt == c_WW'(c_OUT_WORDS - 1));
        w_res_acc      = core_dst_write & res_ready;
        if (w_res_acc) begin
          w_wcnt_nxt = r_wcnt + 1'b1;
          w_tcnt_nxt = '0;
          if (r_wcnt == c_WW'(c_OUT_WORDS - 1)) begin
            w_ptr_nxt   = r_grant;
            w_fcnt_nxt  = 1'b0;
            w_state_nxt = S_FLUSH;
          end
        end else if (r_tcnt == c_TW'(TIMEOUT - 1)) begin
          // Abort: words already delivered stay delivered, no res_last
          err         = 1'b1;
          w_ptr_nxt   = r_grant;
          w_fcnt_nxt  = 1'b0;
          w_state_nxt = S_FLUSH;
        end else begin
          w_tcnt_nxt = r_tcnt + 1'b1;
        end
      end

      S_FLUSH: begin
        // Two-cycle core reset before the next job
        core_rst = 1'b1;
        if (r_fcnt) begin
          w_fcnt_nxt  = 1'b0;
          w_state_nxt = S_IDLE;
        end else begin
          w_fcnt_nxt = 1'b1;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ptr   <= c_PW'(NREQ - 1);
      r_grant <= '0;
      r_wcnt  <= '0;
      r_tcnt  <= '0;
      r_fcnt  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_tcnt  <= w_tcnt_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keccak_job_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_keccak_job_scheduler
// Description : Directed self-checking bench; the bench plays the keccak core
//               and the requesters, and checks arbitration order, data paths,
//               backpressure, timeout abort, flush and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keccak_job_scheduler;

  localparam int NREQ    = 4;
  localparam int HS      = 512;
  localparam int TIMEOUT = 16;
  localparam int OUTW    = HS / 64;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [NREQ-1:0]    req_valid = '0;
  logic [63:0]        rdata [NREQ];
  logic [NREQ*64-1:0] req_data;
  logic [NREQ-1:0]    req_last = '0;
  logic [NREQ-1:0]    req_ready;
  logic               core_rst, core_src_ready, core_dst_ready;
  logic               core_src_read = 1'b0;
  logic [63:0]        core_din;
  logic               core_dst_write = 1'b0;
  logic [63:0]        core_dout = '0;
  logic               res_valid, res_last, busy, err;
  logic [63:0]        res_data;
  logic [2:0]         res_id;
  logic               res_ready = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_data[64*g +: 64] = rdata[g];
  end

  keccak_job_scheduler #(.NREQ(NREQ), .HS(HS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .core_rst(core_rst), .core_src_ready(core_src_ready), .core_src_read(core_src_read),
    .core_din(core_din), .core_dst_ready(core_dst_ready), .core_dst_write(core_dst_write),
    .core_dout(core_dout), .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_last(res_last), .res_ready(res_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] wp(input int id, input int w);
    return 64'hA5A5_0000_0000_0000 | (64'(id) << 16) | 64'(w);
  endfunction

  function automatic logic [63:0] dp(input int id, input int k);
    return 64'hD16E_0000_0000_0000 | (64'(id) << 8) | 64'(k);
  endfunction

  task automatic do_reset();
    reset          = 1'b1;
    req_valid      = '0;
    req_last       = '0;
    core_src_read  = 1'b0;
    core_dst_write = 1'b0;
    res_ready      = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Serve one message from requester id: wait for FEED, stream nwords, then
  // either return OUTW digest words (optionally stalling the sink on word
  // stall_at) or never write (timeout), then check the flush.
  task automatic serve(input int id, input int nwords, input int stall_at,
                       input bit no_write, input bit keep_valid);
    int waited;
    int acc;
    int tcyc;
    logic [NREQ-1:0] onehot;
    onehot = NREQ'(1) << id;
    waited = 0;
    core_src_read = 1'b1;
    while (!busy && waited < 20) begin
      step();
      waited++;
    end
    check("feed_entry", busy, 1);
    acc = 0;
    for (int w = 0; w < nwords; w++) begin
      rdata[id]    = wp(id, w);
      req_last[id] = (w == nwords - 1);
      #1;
      check("src_ready_n", core_src_ready, 0);
      check("din", core_din, wp(id, w));
      check("req_ready_onehot", req_ready, onehot);
      if (req_ready[id]) acc++;
      step();
    end
    check("feed_accepts", acc, nwords);
    req_last      = '0;
    core_src_read = 1'b0;
    if (!keep_valid) req_valid[id] = 1'b0;

    if (no_write) begin
      core_dst_write = 1'b0;
      res_ready      = 1'b1;
      tcyc = -1;
      for (int c = 0; c < 40; c++) begin
        #1;
        if (err) begin
          tcyc = c;
          break;
        end
        step();
      end
      check("timeout_cycle", tcyc, 15);
      check("abort_res_valid", res_valid, 0);
      step();
      #1;
      check("err_pulse_len", err, 0);
    end else begin
      res_ready      = 1'b1;
      core_dst_write = 1'b1;
      for (int k = 0; k < OUTW; k++) begin
        core_dout = dp(id, k);
        if (k == stall_at) begin
          res_ready = 1'b0;
          for (int s = 0; s < 10; s++) begin
            #1;
            check("stall_dst_ready", core_dst_ready, 1);
            check("stall_res_data", res_data, dp(id, k));
            step();
          end
          res_ready = 1'b1;
        end
        #1;
        check("dst_ready_n", core_dst_ready, 0);
        check("res_valid", res_valid, 1);
        check("res_data", res_data, dp(id, k));
        check("res_id", res_id, id);
        check("res_last", res_last, (k == OUTW - 1));
        step();
      end
      core_dst_write = 1'b0;
      #1;
    end
    check("flush_rst1", core_rst, 1);
    check("flush_busy", busy, 1);
    step();
    #1;
    check("flush_rst2", core_rst, 1);
    step();
    #1;
    check("idle_rst", core_rst, 0);
    check("idle_busy", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) rdata[i] = 64'h0;

    // T1: reset values, then a 3-word message from requester 0
    reset = 1'b1;
    step();
    step();
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_core_rst", core_rst, 1);
    check("rst_src_ready", core_src_ready, 1);
    check("rst_dst_ready", core_dst_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    req_valid = 4'b0001;
    serve(0, 3, -1, 1'b0, 1'b0);

    // T2: requesters 0 and 2 together, twice
    do_reset();
    req_valid = 4'b0101;
    serve(0, 2, -1, 1'b0, 1'b0);
    serve(2, 2, -1, 1'b0, 1'b0);
    req_valid = 4'b0101;
    serve(0, 1, -1, 1'b0, 1'b0);
    serve(2, 1, -1, 1'b0, 1'b0);

    // T3: all requesters continuously valid
    do_reset();
    req_valid = 4'b1111;
    serve(0, 1, -1, 1'b0, 1'b1);
    serve(1, 1, -1, 1'b0, 1'b1);
    serve(2, 1, -1, 1'b0, 1'b1);
    serve(3, 1, -1, 1'b0, 1'b1);
    serve(0, 1, -1, 1'b0, 1'b1);

    // T4: sink stalls for 10 cycles on digest word index 3
    do_reset();
    req_valid = 4'b0010;
    serve(1, 2, 3, 1'b0, 1'b0);

    // T5: core never writes, timeout abort, next requester served
    do_reset();
    req_valid = 4'b0011;
    serve(0, 1, -1, 1'b1, 1'b0);
    serve(1, 1, -1, 1'b0, 1'b0);

    // T6: reset mid-FEED drops the message
    do_reset();
    req_valid     = 4'b0011;
    core_src_read = 1'b1;
    rdata[0]      = wp(0, 0);
    step();
    #1;
    check("t6_word0_ready", req_ready, 4'b0001);
    step();
    rdata[0] = wp(0, 1);
    reset    = 1'b1;
    step();
    #1;
    check("t6_core_rst", core_rst, 1);
    check("t6_req_ready", req_ready, 0);
    check("t6_busy", busy, 0);
    reset = 1'b0;
    serve(0, 5, -1, 1'b0, 1'b0);
    serve(1, 1, -1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
